// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if
//   Bus bundle for regfile_multiport: read ports, dual write ports,
//   reservation request and busy population count.
//   master: decode/writeback side (drives indices, writes, reserve)
//   slave : register file (drives readValue, readBusy, busyCount)
//   Parameters must match those of the regfile_multiport instance.
interface regfile_multiport_if #(
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned REGISTER_NUMBER_LOG = 5,
    parameter int unsigned READ_PORTS          = 2
);
    logic [READ_PORTS*REGISTER_NUMBER_LOG-1:0] readIndex;
    logic [READ_PORTS*DATA_WIDTH-1:0]          readValue;
    logic [READ_PORTS-1:0]                     readBusy;
    logic [1:0]                                writeEnable;
    logic [2*REGISTER_NUMBER_LOG-1:0]          writeIndex;
    logic [2*DATA_WIDTH-1:0]                   writeValue;
    logic                                      reserveEnable;
    logic [REGISTER_NUMBER_LOG-1:0]            reserveIndex;
    logic [REGISTER_NUMBER_LOG:0]              busyCount;

    modport master (
        output readIndex, writeEnable, writeIndex, writeValue, reserveEnable, reserveIndex,
        input  readValue, readBusy, busyCount
    );

    modport slave (
        input  readIndex, writeEnable, writeIndex, writeValue, reserveEnable, reserveIndex,
        output readValue, readBusy, busyCount
    );
endinterface

// File: rtl/regfile_multiport.sv
// regfile_multiport
//   Multi-port register file with per-register busy (scoreboard) bits.
//   Reads are combinational; two write ports and one reservation port
//   update state on the rising edge of clk.
// Ports:
//   clk   - clock, all state updates on rising edge
//   reset - synchronous, active-high; clears storage, busy bits and busyCount
//   bus   - regfile_multiport_if.slave: readIndex/readValue/readBusy,
//           writeEnable/writeIndex/writeValue, reserveEnable/reserveIndex,
//           busyCount
// Optional feature:
//   REGFILE_BYPASS_EN - when defined, reads matching an enabled write port
//   in the same cycle forward that write data (port 1 has priority).
module regfile_multiport #(
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned REGISTER_NUMBER_LOG = 5,
    parameter int unsigned READ_PORTS          = 2,
    parameter int unsigned ZERO_REG            = 1
) (
    input logic                clk,
    input logic                reset,
    regfile_multiport_if.slave bus
);
    localparam int unsigned Depth  = 2 ** REGISTER_NUMBER_LOG;
    localparam int unsigned CountW = REGISTER_NUMBER_LOG + 1;

    logic [DATA_WIDTH-1:0]          storage_q [Depth];
    logic [DATA_WIDTH-1:0]          storage_d [Depth];
    logic [Depth-1:0]               busy_q, busy_d;
    logic [CountW-1:0]              busy_count_q, busy_count_d;

    logic [REGISTER_NUMBER_LOG-1:0] wr_idx [2];
    logic [DATA_WIDTH-1:0]          wr_val [2];

    always_comb begin
        for (int unsigned w = 0; w < 2; w++) begin
            wr_idx[w] = bus.writeIndex[w*REGISTER_NUMBER_LOG +: REGISTER_NUMBER_LOG];
            wr_val[w] = bus.writeValue[w*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Next state: port 0 then port 1 so port 1 wins a same-index conflict;
    // the reservation is applied last because it is the newer producer.
    always_comb begin
        storage_d = storage_q;
        busy_d    = busy_q;
        for (int unsigned w = 0; w < 2; w++) begin
            if (bus.writeEnable[w]) begin
                storage_d[wr_idx[w]] = wr_val[w];
                busy_d[wr_idx[w]]    = 1'b0;
            end
        end
        if (bus.reserveEnable) begin
            busy_d[bus.reserveIndex] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            storage_d[0] = '0;
            busy_d[0]    = 1'b0;
        end
    end

    // Population count of the post-edge busy vector; bit 0 is already
    // forced clear when the zero register is enabled.
    always_comb begin
        busy_count_d = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            busy_count_d = busy_count_d + CountW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                storage_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            storage_q    <= storage_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign bus.busyCount = busy_count_q;

    // Read ports
    always_comb begin
        logic [REGISTER_NUMBER_LOG-1:0] idx;
        logic [DATA_WIDTH-1:0]          val;
        logic                           bsy;
        bus.readValue = '0;
        bus.readBusy  = '0;
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            idx = bus.readIndex[p*REGISTER_NUMBER_LOG +: REGISTER_NUMBER_LOG];
            val = storage_q[idx];
            bsy = busy_q[idx];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned w = 0; w < 2; w++) begin
                if (bus.writeEnable[w] && (wr_idx[w] == idx)) begin
                    val = wr_val[w];
                    bsy = bus.reserveEnable && (bus.reserveIndex == idx);
                end
            end
`endif
            if ((ZERO_REG != 0) && (idx == '0)) begin
                val = '0;
                bsy = 1'b0;
            end
            bus.readValue[p*DATA_WIDTH +: DATA_WIDTH] = val;
            bus.readBusy[p]                           = bsy;
        end
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport
//   Directed bench for regfile_multiport (32x32, two read ports, zero reg).
//   Stimulus pushes expected responses into a queue each cycle; a monitor
//   on the falling edge pops and compares them against the DUT outputs.
module tb_regfile_multiport;
    localparam int unsigned DW = 32;
    localparam int unsigned RL = 5;
    localparam int unsigned RP = 2;

    logic clk;
    logic reset;

    regfile_multiport_if #(.DATA_WIDTH(DW), .REGISTER_NUMBER_LOG(RL), .READ_PORTS(RP)) bus ();

    regfile_multiport #(
        .DATA_WIDTH         (DW),
        .REGISTER_NUMBER_LOG(RL),
        .READ_PORTS         (RP),
        .ZERO_REG           (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = readValue[port], 1 = readBusy[port], 2 = busyCount
    typedef struct packed {
        int          kind;
        int          port;
        logic [31:0] v;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string nm, input int kind, input int port, input logic [31:0] v);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.v    = v;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic chk_rd(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic ba, input logic bb);
        chk({nm, ".valA"}, 0, 0, a);
        chk({nm, ".valB"}, 0, 1, b);
        chk({nm, ".busyA"}, 1, 0, {31'd0, ba});
        chk({nm, ".busyB"}, 1, 1, {31'd0, bb});
    endtask

    // Monitor: compares queued expectations mid-cycle
    initial begin : monitor
        exp_t        e;
        string       nm;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                case (e.kind)
                    0:       act = bus.readValue[e.port*DW +: DW];
                    1:       act = {31'd0, bus.readBusy[e.port]};
                    default: act = {26'd0, bus.busyCount};
                endcase
                n_checks++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, e.v);
                end
            end
        end
    end

    // Advance to just after the next rising edge and idle the write side
    task automatic step();
        @(posedge clk);
        #1;
        reset             = 1'b0;
        bus.writeEnable   = 2'b00;
        bus.reserveEnable = 1'b0;
    endtask

    task automatic rd(input int a, input int b);
        bus.readIndex = {5'(b), 5'(a)};
    endtask

    task automatic wr(input int port, input int idx, input logic [31:0] v);
        bus.writeEnable[port]                = 1'b1;
        bus.writeIndex[port*RL +: RL]        = 5'(idx);
        bus.writeValue[port*DW +: DW]        = v;
    endtask

    task automatic rsv(input int idx);
        bus.reserveEnable = 1'b1;
        bus.reserveIndex  = 5'(idx);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] exp_byp;
        reset             = 1'b1;
        bus.readIndex     = '0;
        bus.writeEnable   = 2'b00;
        bus.writeIndex    = '0;
        bus.writeValue    = '0;
        bus.reserveEnable = 1'b0;
        bus.reserveIndex  = '0;
        // Write garbage during the reset edge; it must be ignored
        wr(0, 3, 32'hDEAD_BEEF);
        rsv(3);

        // Reset contents
        for (int i = 0; i < 32; i++) begin
            step();
            rd(i, i);
            chk_rd("reset", 32'd0, 32'd0, 1'b0, 1'b0);
            chk("reset.count", 2, 0, 32'd0);
        end

        // Write idx i = i, then attempt a write of index 0
        for (int i = 2; i < 32; i++) begin
            step();
            wr(0, i, 32'(i));
        end
        step();
        wr(0, 0, 32'hFFFF_FFFF);
        for (int i = 2; i < 31; i++) begin
            step();
            rd(i, i + 1);
            chk_rd("wrrd", 32'(i), 32'(i + 1), 1'b0, 1'b0);
        end
        step();
        rd(0, 1);
        chk_rd("zero", 32'd0, 32'd0, 1'b0, 1'b0);

        // Write/write conflict: port 1 wins
        step();
        wr(0, 5, 32'h11);
        wr(1, 5, 32'h22);
        step();
        rd(5, 31);
        chk_rd("conflict", 32'h22, 32'd31, 1'b0, 1'b0);

        // Scoreboard: reserve, release, reserve+write
        step();
        rsv(7);
        step();
        rd(7, 6);
        chk_rd("rsv7", 32'd7, 32'd6, 1'b1, 1'b0);
        chk("rsv7.count", 2, 0, 32'd1);
        step();
        wr(1, 7, 32'h7);
        step();
        rd(7, 6);
        chk_rd("rel7", 32'd7, 32'd6, 1'b0, 1'b0);
        chk("rel7.count", 2, 0, 32'd0);
        step();
        rsv(7);
        wr(0, 7, 32'h7);
        step();
        rd(7, 0);
        chk_rd("rsvwr7", 32'd7, 32'd0, 1'b1, 1'b0);
        chk("rsvwr7.count", 2, 0, 32'd1);

        // Reservation of index 0 is dropped
        step();
        rsv(0);
        step();
        rd(0, 7);
        chk_rd("rsv0", 32'd0, 32'd7, 1'b0, 1'b1);
        chk("rsv0.count", 2, 0, 32'd1);

        // Same-cycle read of a register being written
        step();
        wr(0, 9, 32'hABCD);
        wr(0, 10, 32'h1);
        wr(1, 10, 32'h2);
        wr(0, 9, 32'hABCD);
        rd(9, 10);
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'h2;
        chk_rd("byp", 32'hABCD, exp_byp, 1'b0, 1'b0);
`else
        exp_byp = 32'd10;
        chk_rd("byp", 32'd9, exp_byp, 1'b0, 1'b0);
`endif
        step();
        rd(9, 31);
        chk_rd("byp.after", 32'hABCD, 32'd31, 1'b0, 1'b0);

        // Write port 1 to idx 10 on its own, then check
        step();
        wr(1, 10, 32'h2);
        step();
        rd(10, 9);
        chk_rd("p1wr", 32'h2, 32'hABCD, 1'b0, 1'b0);

        // Reset mid-operation
        step();
        wr(0, 1, 32'h101);
        wr(1, 2, 32'h102);
        step();
        wr(0, 3, 32'h103);
        wr(1, 4, 32'h104);
        rsv(4);
        step();
        rd(1, 4);
        chk_rd("fill", 32'h101, 32'h104, 1'b0, 1'b1);
        chk("fill.count", 2, 0, 32'd2);
        step();
        reset = 1'b1;
        wr(0, 1, 32'h55);
        rsv(5);
        step();
        rd(1, 4);
        chk_rd("rst.a", 32'd0, 32'd0, 1'b0, 1'b0);
        chk("rst.count", 2, 0, 32'd0);
        step();
        rd(2, 3);
        chk_rd("rst.b", 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        rd(5, 7);
        chk_rd("rst.c", 32'd0, 32'd0, 1'b0, 1'b0);

        step();
        step();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
